// File: rtl/mmio_port_responder_pkg.sv
// Shared constants for the MIPS memory-mapped I/O block: register word offsets,
// STATUS/CTRL bit positions and the default window base.
package mips_io_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'hFFFF_0000;

    // Word offsets, compared against Address[5:2]
    localparam logic [3:0] OFF_PORT_OUT      = 4'd0;
    localparam logic [3:0] OFF_PORT_IN       = 4'd1;
    localparam logic [3:0] OFF_STATUS        = 4'd2;
    localparam logic [3:0] OFF_TIMER_COUNT   = 4'd3;
    localparam logic [3:0] OFF_TIMER_COMPARE = 4'd4;
    localparam logic [3:0] OFF_TIMER_CTRL    = 4'd5;

    localparam int STATUS_IN_CHANGED    = 0;
    localparam int STATUS_TIMER_EXPIRED = 1;
    localparam int CTRL_EN              = 0;
    localparam int CTRL_AUTO_RELOAD     = 1;

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-bus signals between the MIPS datapath (master) and the I/O responder (slave).
interface mmio_port_responder_if;

    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Selected;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, Selected
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, Selected
    );

endinterface

// File: rtl/mmio_port_responder_sync.sv
// Two-flop synchronizer for an asynchronous input bus, plus a previous-value
// register so callers get a one-cycle-wide 'changed' indication.
module input_synchronizer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sync,
    output logic              changed
);

    logic [DATA_W-1:0] meta_p0;
    logic [DATA_W-1:0] sync_p1;
    logic [DATA_W-1:0] prev_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= '0;
        end else begin
            meta_p0 <= din;
            // stage boundary: metastability-settled value
            sync_p1 <= meta_p0;
            // stage boundary: value seen one cycle earlier
            prev_p2 <= sync_p1;
        end
    end

    assign sync    = sync_p1;
    assign changed = (sync_p1 != prev_p2);

endmodule

// File: rtl/mmio_port_responder.sv
// MIPS data-bus I/O responder: output port, synchronized input port with sticky
// change flag, and an interval timer compiled in only when MMIO_TIMER_EN is defined.
module mmio_port_responder
    import mips_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_port_responder_if.slave  bus,
    input  logic [7:0]            PortIn,
    output logic [31:0]           PortOut,
    output logic                  Irq
);

    logic [3:0]  offset;
    logic        wr_en;
    logic        unused_addr_bits;
    logic [7:0]  port_in_sync;
    logic        in_changed;
    logic        timer_expire;
    logic [1:0]  status;
    logic [1:0]  status_clr;
    logic [1:0]  status_set;
    logic [31:0] rd_word;

    assign offset           = bus.Address[5:2];
    assign unused_addr_bits = ^bus.Address[1:0];
    assign bus.Selected     = (bus.Address[31:6] == BASE_ADDRESS[31:6]);
    assign wr_en            = bus.MemWrite && bus.Selected;

    input_synchronizer #(
        .DATA_W (8)
    ) u_port_in_sync (
        .clk     (clk),
        .reset   (reset),
        .din     (PortIn),
        .sync    (port_in_sync),
        .changed (in_changed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut <= '0;
        end else if (wr_en && offset == OFF_PORT_OUT) begin
            PortOut <= bus.WriteData;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic [1:0]  ctrl;

    assign timer_expire = ctrl[CTRL_EN] && (count == compare);

    // Register writes come after the count step so a CTRL write overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ctrl    <= '0;
        end else begin
            if (ctrl[CTRL_EN]) begin
                if (count == compare) begin
                    count <= '0;
                    if (!ctrl[CTRL_AUTO_RELOAD]) ctrl[CTRL_EN] <= 1'b0;
                end else begin
                    count <= count + 32'd1;
                end
            end
            if (wr_en && offset == OFF_TIMER_COMPARE) compare <= bus.WriteData;
            if (wr_en && offset == OFF_TIMER_CTRL) begin
                ctrl  <= bus.WriteData[1:0];
                count <= '0;
            end
        end
    end
`else
    assign timer_expire = 1'b0;
`endif

    // Sticky sets win over a same-cycle write-1-to-clear.
    assign status_clr = (wr_en && offset == OFF_STATUS) ? bus.WriteData[1:0] : 2'b00;
    assign status_set = {timer_expire, in_changed};

    always_ff @(posedge clk) begin
        if (reset) begin
            status <= '0;
        end else begin
            status <= (status & ~status_clr) | status_set;
        end
    end

    assign Irq = |status;

    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_PORT_OUT:      rd_word = PortOut;
            OFF_PORT_IN:       rd_word = {24'b0, port_in_sync};
            OFF_STATUS:        rd_word = {30'b0, status};
`ifdef MMIO_TIMER_EN
            OFF_TIMER_COUNT:   rd_word = count;
            OFF_TIMER_COMPARE: rd_word = compare;
            OFF_TIMER_CTRL:    rd_word = {30'b0, ctrl};
`endif
            default:           rd_word = '0;
        endcase
    end

    assign bus.ReadData = (bus.MemRead && bus.Selected) ? rd_word : '0;

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the MIPS processor's data bus; the target end of the load/store accesses the datapath issues alongside the data memory. Maps a parallel output port, a synchronized 8-bit input port with sticky change detection, and a programmable interval timer into a 32-bit word address window. Reads are combinational for the single-cycle core; writes commit on the clock edge. The top level steers `ReadData` from this block whenever `Selected` is high.

## Interface
- `BASE_ADDRESS`, 32'hFFFF_0000: base of the 64-byte I/O window; must be 64-byte aligned.
- `clk`  in  1: processor clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `MemWrite`  in  1: store strobe from Control.
- `MemRead`  in  1: load strobe from Control.
- `Address`  in  32: ALU result (byte address).
- `WriteData`  in  32: register-file ReadData2.
- `PortIn`  in  8: asynchronous external input pins.
- `ReadData`  out  32: read data; 0 when not selected or when `MemRead` is low.
- `Selected`  out  1: `Address[31:6] == BASE_ADDRESS[31:6]`.
- `PortOut`  out  32: output port register.
- `Irq`  out  1: OR of the STATUS bits.

## Operation
- Offset `Address[5:2]`. `Address[1:0]` is ignored.
  - 0x00 PORT_OUT: RW.
  - 0x04 PORT_IN: RO, zero-extended synchronized value.
  - 0x08 STATUS: bit0 IN_CHANGED, bit1 TIMER_EXPIRED; write-1-to-clear.
  - 0x0C TIMER_COUNT: RO.
  - 0x10 TIMER_COMPARE: RW.
  - 0x14 TIMER_CTRL: bit0 EN, bit1 AUTO_RELOAD.
- Unmapped offsets read 0. Writes to them and to RO registers are ignored.
- A write occurs when `MemWrite && Selected`. Reads have no side effects.
- Input path:
  - Two-flop synchronizer, then a registered previous value.
  - IN_CHANGED sets when the synchronized value differs from the previous value.
- Timer:
  - Any write to TIMER_CTRL clears the count to 0.
  - On each cycle with EN=1: if count == compare, TIMER_EXPIRED sets. Then count becomes 0 if AUTO_RELOAD=1; otherwise count becomes 0 and EN clears.
  - Otherwise count increments by 1, with 32-bit wrap.
- Simultaneous events:
  - A sticky set and a W1C of the same bit in the same cycle: the set wins.
  - A TIMER_COMPARE write and an expiry check in the same cycle: the check uses the old compare value.
  - A TIMER_CTRL write in the expiry cycle: the written value wins. The expiry bit still sets.
- Reset: `PortOut`=0, STATUS=0, count=0, compare=0, CTRL=0, and synchronizer/previous flops = 0. `Irq`=0.
  - `ReadData` is combinational, so it returns reset register values.
  - Reset asserted mid-count returns all of the above to these values on the next edge.

## Timing
- Read latency 0: `ReadData` follows `Address` and `MemRead` in the same cycle.
- Write latency 1: the register holds the new value after the edge on which `MemWrite` was sampled.
- PortIn to PORT_IN readable value: 2 edges.
- PortIn change to IN_CHANGED and `Irq`: 3 edges.
- Timer with compare N, CTRL written EN=1 at edge E:
  - TIMER_EXPIRED sets at edge E+N+1.
  - With AUTO_RELOAD, the period is N+1 cycles.
- `Irq` is a registered-state function: 0 cycles after the STATUS update.

## Configuration
- `MMIO_TIMER_EN` defined: the timer registers and the TIMER_EXPIRED bit are implemented as above.
- Undefined:
  - Offsets 0x0C–0x14 read 0 and ignore writes.
  - STATUS bit1 is constant 0.
  - No timer flops are synthesized.

## Structure
- Shared package `mips_io_pkg` holds:
  - offset constants: `OFF_PORT_OUT`, `OFF_PORT_IN`, `OFF_STATUS`, `OFF_TIMER_COUNT`, `OFF_TIMER_COMPARE`, `OFF_TIMER_CTRL`;
  - STATUS/CTRL bit indices;
  - default `BASE_ADDRESS`.
- Sub-module `input_synchronizer`, parameterized width: two-flop synchronizer, previous-value register and `changed` pulse output. It is reused for future input ports.
- The timer is an inline `ifdef` region in the top module. It does not get its own module.

## Test plan
- Reset, then read all six offsets with `MemRead`=1 → all return 0. `PortOut`=0, `Irq`=0.
- Store 32'hA5A5_0F0F to 0xFFFF0000 → `PortOut`=32'hA5A5_0F0F after 1 edge. A store to 0x1001_0000 leaves `PortOut` unchanged, with `Selected`=0.
- Drive `PortIn` 0x00→0x3C at edge k:
  - PORT_IN reads 0x3C from k+2.
  - STATUS bit0 and `Irq` are set at k+3.
  - Write 1 to STATUS → bit0 clears next edge.
  - W1C in the same cycle as a new change → bit0 stays 1.
- Compare=3, CTRL=0x1 at edge E:
  - Count reads 1, 2, 3 at E+1..E+3.
  - Expiry at E+4, with count=0 and EN=0.
  - With CTRL=0x3, expiry repeats every 4 cycles.
- Assert `reset` while the timer runs with count=2 → next edge: count 0, CTRL 0, STATUS 0, `PortOut` 0.
- Build without `MMIO_TIMER_EN`: write 5 to 0x10 and 1 to 0x14, wait 20 cycles → 0x0C/0x10/0x14 read 0, STATUS bit1=0.
